// File: rtl/wb_mem_arbiter.sv
// Two-master round-robin Wishbone arbiter with cycle-locked grants and a slave watchdog.
// Grant lands one cycle after the request is seen; the owner holds the bus until it drops cyc.
module wb_mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_adr_i,
  input  logic [DATA_W-1:0] m0_dat_i,
  input  logic              m0_we_i,
  input  logic [3:0]        m0_sel_i,
  input  logic              m0_stb_i,
  input  logic              m0_cyc_i,
  output logic [DATA_W-1:0] m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic              m0_rty_o,
  input  logic [ADDR_W-1:0] m1_adr_i,
  input  logic [DATA_W-1:0] m1_dat_i,
  input  logic              m1_we_i,
  input  logic [3:0]        m1_sel_i,
  input  logic              m1_stb_i,
  input  logic              m1_cyc_i,
  output logic [DATA_W-1:0] m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              m1_rty_o,
  output logic [ADDR_W-1:0] s_adr_o,
  output logic [DATA_W-1:0] s_dat_o,
  output logic              s_we_o,
  output logic [3:0]        s_sel_o,
  output logic              s_stb_o,
  output logic              s_cyc_o,
  input  logic [DATA_W-1:0] s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  input  logic              s_rty_i,
  output logic [1:0]        grant_o,
  output logic              timeout_o
);

  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);
  localparam int WD_W  = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_EN ? WD_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [WD_W-1:0] WD_MAX  = '1;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;    // 0 = M0 was granted last, 1 = M1
  logic              own_q, own_d;      // master that was aborted
  logic              pulse_q, pulse_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  logic in_gnt, cur_own, own_cyc, own_stb, resp, wd_hit;

  function automatic state_t arb(input logic c0, input logic c1, input logic last);
    if (c0 && c1) return last ? GNT0 : GNT1;
    else if (c0)  return GNT0;
    else if (c1)  return GNT1;
    else          return IDLE;
  endfunction

  always_comb begin
    in_gnt  = (state_q == GNT0) || (state_q == GNT1);
    cur_own = (state_q == ABORT) ? own_q : (state_q == GNT1);
    own_cyc = cur_own ? m1_cyc_i : m0_cyc_i;
    own_stb = cur_own ? m1_stb_i : m0_stb_i;
    resp    = s_ack_i | s_err_i | s_rty_i;
    // A response on the final watchdog cycle wins over the abort.
    wd_hit  = WD_EN && in_gnt && own_stb && !resp && (wd_q == WD_LAST);
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    own_d   = own_q;
    pulse_d = 1'b0;
    wd_d    = '0;
    case (state_q)
      IDLE: state_d = arb(m0_cyc_i, m1_cyc_i, last_q);
      GNT0, GNT1: begin
        if (!own_cyc) begin
          state_d = arb(m0_cyc_i, m1_cyc_i, last_q);
        end else if (wd_hit) begin
          state_d = ABORT;
          own_d   = cur_own;
          pulse_d = 1'b1;
        end
      end
      ABORT: if (!own_cyc) state_d = arb(m0_cyc_i, m1_cyc_i, last_q);
      default: state_d = IDLE;
    endcase
    if (in_gnt && (state_d == state_q)) begin
      if (resp)
        wd_d = '0;
      else if (WD_EN && own_stb && (wd_q != WD_MAX))
        wd_d = wd_q + 1'b1;
      else
        wd_d = wd_q;
    end
    if (state_d == GNT0) last_d = 1'b0;
    if (state_d == GNT1) last_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      own_q   <= 1'b0;
      pulse_q <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      own_q   <= own_d;
      pulse_q <= pulse_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    s_stb_o   = 1'b0;
    s_cyc_o   = 1'b0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m0_rty_o  = 1'b0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    m1_rty_o  = 1'b0;
    m0_dat_o  = s_dat_i;
    m1_dat_o  = s_dat_i;
    timeout_o = 1'b0;
    grant_o   = {state_q == GNT1, state_q == GNT0};
    if (state_q == GNT0) begin
      s_adr_o  = m0_adr_i;
      s_dat_o  = m0_dat_i;
      s_we_o   = m0_we_i;
      s_sel_o  = m0_sel_i;
      s_stb_o  = m0_stb_i;
      s_cyc_o  = m0_cyc_i;
      m0_ack_o = s_ack_i;
      m0_err_o = s_err_i;
      m0_rty_o = s_rty_i;
    end else if (state_q == GNT1) begin
      s_adr_o  = m1_adr_i;
      s_dat_o  = m1_dat_i;
      s_we_o   = m1_we_i;
      s_sel_o  = m1_sel_i;
      s_stb_o  = m1_stb_i;
      s_cyc_o  = m1_cyc_i;
      m1_ack_o = s_ack_i;
      m1_err_o = s_err_i;
      m1_rty_o = s_rty_i;
    end else if (state_q == ABORT) begin
      // Slave responses are ignored here; only the one-shot abort error is signalled.
      timeout_o = pulse_q;
      m0_err_o  = pulse_q && !own_q;
      m1_err_o  = pulse_q && own_q;
    end
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: zero-wait slave model plus per-master scoreboards of expected transfers.
module tb_wb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
  logic        m0_we_i, m0_stb_i, m0_cyc_i, m1_we_i, m1_stb_i, m1_cyc_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic        s_we_o, s_stb_o, s_cyc_o, s_ack_i, s_err_i, s_rty_i;
  logic [3:0]  s_sel_o;
  logic [1:0]  grant_o;
  logic        timeout_o;
  logic        ack_en, ack_force;

  localparam logic [31:0] RD_KEY = 32'h5A5A_0F0F;

  always #5 clk = ~clk;

  assign s_ack_i = ack_force | (s_cyc_o & s_stb_o & ack_en);
  assign s_dat_i = s_adr_o ^ RD_KEY;
  assign s_err_i = 1'b0;
  assign s_rty_i = 1'b0;

  wb_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i),
    .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i),
    .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .s_rty_i(s_rty_i), .grant_o(grant_o), .timeout_o(timeout_o)
  );

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } txn_t;

  txn_t sb0[$];
  txn_t sb1[$];
  int   total = 0;
  int   bad = 0;
  int   ack0_cnt = 0;
  int   ack1_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_txn(input string who, input txn_t e, input logic [31:0] rdat);
    chk({who, "_adr"}, s_adr_o, e.adr);
    chk({who, "_we"}, s_we_o, e.we);
    if (e.we) begin
      chk({who, "_wdat"}, s_dat_o, e.dat);
      chk({who, "_sel"}, s_sel_o, e.sel);
    end else begin
      chk({who, "_rdat"}, rdat, e.adr ^ RD_KEY);
    end
  endtask

  always @(negedge clk) begin
    txn_t e;
    if (m0_ack_o) begin
      ack0_cnt++;
      if (sb0.size() == 0) chk("m0_extra_ack", m0_ack_o, 1'b0);
      else begin e = sb0.pop_front(); check_txn("m0", e, m0_dat_o); end
    end
    if (m1_ack_o) begin
      ack1_cnt++;
      if (sb1.size() == 0) chk("m1_extra_ack", m1_ack_o, 1'b0);
      else begin e = sb1.pop_front(); check_txn("m1", e, m1_dat_o); end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int m, input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input bit push);
    txn_t e;
    e.we = we; e.adr = adr; e.dat = dat; e.sel = sel;
    if (m == 0) begin
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat; m0_sel_i = sel;
      if (push) sb0.push_back(e);
    end else begin
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat; m1_sel_i = sel;
      if (push) sb1.push_back(e);
    end
  endtask

  task automatic drop(input int m);
    if (m == 0) begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m0_we_i = 1'b0; end
    else        begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0; end
  endtask

  task automatic wait_ack(input int m, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = (m == 0) ? m0_ack_o : m1_ack_o;
    end
    if (!seen) chk(tag, seen, 1'b1);
  endtask

  function automatic logic [1:0] gbit(input int m);
    return (m == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic tie_round(input int first, input string tag);
    int second;
    second = 1 - first;
    req(0, 1'b0, 32'h0000_0100, 32'h0, 4'hF, 1'b1);
    req(1, 1'b0, 32'h0000_0200, 32'h0, 4'hF, 1'b1);
    tick();
    chk({tag, "_first"}, grant_o, gbit(first));
    wait_ack(first, {tag, "_ack_first"});
    tick();
    drop(first);
    #1 chk({tag, "_hold"}, grant_o, gbit(first));
    tick();
    chk({tag, "_second"}, grant_o, gbit(second));
    wait_ack(second, {tag, "_ack_second"});
    tick();
    drop(second);
    tick();
    chk({tag, "_idle"}, grant_o, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0;
    rst = 1'b1; ack_en = 1'b1; ack_force = 1'b0;
    m0_adr_i = '0; m0_dat_i = '0; m0_we_i = 1'b0; m0_sel_i = '0; m0_stb_i = 1'b0; m0_cyc_i = 1'b1;
    m1_adr_i = '0; m1_dat_i = '0; m1_we_i = 1'b0; m1_sel_i = '0; m1_stb_i = 1'b0; m1_cyc_i = 1'b1;

    // Reset held with both masters requesting.
    repeat (2) begin
      tick();
      chk("rst_grant", grant_o, 2'b00);
      chk("rst_scyc", s_cyc_o, 1'b0);
      chk("rst_timeout", timeout_o, 1'b0);
      chk("rst_acks", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 4'b0);
    end
    rst = 1'b0;
    tick();
    chk("rel_grant", grant_o, 2'b01);
    drop(0); drop(1);
    tick();
    chk("rel_idle", grant_o, 2'b00);

    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Round-robin ties.
    tie_round(0, "tie1");
    req(0, 1'b0, 32'h0000_0300, 32'h0, 4'hF, 1'b1);
    tick();
    chk("solo_m0", grant_o, 2'b01);
    wait_ack(0, "solo_ack");
    tick(); drop(0); tick();
    tie_round(1, "tie3");

    // Locked 4-beat M0 line fill with M1 waiting, then M1 write routing.
    a0 = ack0_cnt;
    req(0, 1'b0, 32'h8000_0010, 32'h0, 4'hF, 1'b1);
    tick();
    chk("lock_g0", grant_o, 2'b01);
    req(1, 1'b1, 32'h1000_0000, 32'hDEAD_BEEF, 4'hF, 1'b1);
    #1 chk("lock_m1ack", m1_ack_o, 1'b0);
    for (int b = 1; b < 4; b++) begin
      tick();
      req(0, 1'b0, 32'h8000_0010 + 32'(4 * b), 32'h0, 4'hF, 1'b1);
      #1;
      chk("lock_grant", grant_o, 2'b01);
      chk("lock_m1ack", m1_ack_o, 1'b0);
    end
    tick();
    drop(0);
    #1;
    chk("lock_hold", grant_o, 2'b01);
    chk("lock_beats", ack0_cnt - a0, 4);
    tick();
    chk("lock_handoff", grant_o, 2'b10);
    chk("route_adr", s_adr_o, 32'h1000_0000);
    chk("route_dat", s_dat_o, 32'hDEAD_BEEF);
    chk("route_sel", s_sel_o, 4'hF);
    chk("route_we", s_we_o, 1'b1);
    chk("route_m0ack", m0_ack_o, 1'b0);
    wait_ack(1, "route_ack");
    tick(); drop(1); tick();
    chk("route_idle", grant_o, 2'b00);

    // Watchdog abort on a silent slave.
    ack_en = 1'b0;
    req(1, 1'b0, 32'h2000_0040, 32'h0, 4'hF, 1'b0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("wd_quiet", timeout_o, 1'b0);
      chk("wd_scyc", s_cyc_o, 1'b1);
    end
    tick();
    chk("wd_timeout", timeout_o, 1'b1);
    chk("wd_err", m1_err_o, 1'b1);
    chk("wd_scyc_abort", s_cyc_o, 1'b0);
    chk("wd_m0err", m0_err_o, 1'b0);
    req(0, 1'b0, 32'h0000_0500, 32'h0, 4'hF, 1'b1);
    ack_force = 1'b1;
    #1 chk("abort_late_ack", m1_ack_o, 1'b0);
    tick();
    ack_force = 1'b0;
    chk("wd_pulse_end", timeout_o, 1'b0);
    chk("wd_err_end", m1_err_o, 1'b0);
    drop(1);
    ack_en = 1'b1;
    tick();
    chk("wd_m0_after", grant_o, 2'b01);
    wait_ack(0, "wd_m0_ack");
    tick(); drop(0); tick();

    // Response on the exact timeout cycle.
    ack_en = 1'b0;
    req(1, 1'b0, 32'h3000_0080, 32'h0, 4'hF, 1'b1);
    repeat (8) tick();
    ack_en = 1'b1;
    #1 chk("race_ack", m1_ack_o, 1'b1);
    tick();
    chk("race_timeout", timeout_o, 1'b0);
    chk("race_err", m1_err_o, 1'b0);
    chk("race_grant", grant_o, 2'b10);
    drop(1);
    tick();

    // Reset in the middle of a transfer.
    ack_en = 1'b0;
    req(0, 1'b0, 32'h4000_0000, 32'h0, 4'hF, 1'b0);
    tick();
    chk("mr_scyc", s_cyc_o, 1'b1);
    rst = 1'b1;
    tick();
    ack_en = 1'b1;
    #1;
    chk("mr_scyc_rst", s_cyc_o, 1'b0);
    chk("mr_ack", m0_ack_o, 1'b0);
    chk("mr_grant", grant_o, 2'b00);
    rst = 1'b0;
    drop(0);
    tick();
    chk("mr_idle", grant_o, 2'b00);

    chk("sb0_left", sb0.size(), 0);
    chk("sb1_left", sb1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
